// File: rtl/axil_regbank_if.sv
// AXI4-Lite channel bundle shared by the register bank and its master.
interface axil_regbank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite register bank. AW and W each have a one-entry
// holding slot; a write commits once both slots are full and B is free.
// Read-only registers return hw_in and reject writes with SLVERR.
module axil_regbank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    axil_regbank_if.slave                  s_axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam int         LSB        = $clog2(STRB_WIDTH);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                           aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0]          aw_addr_q, aw_addr_d;
    logic                           w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0]          w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0]          w_strb_q, w_strb_d;
    logic                           bvalid_q, bvalid_d;
    logic [1:0]                     bresp_q, bresp_d;
    logic                           rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
    logic [1:0]                     rresp_q, rresp_d;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]            wr_pulse_q, wr_pulse_d;

    logic                  aw_hs, w_hs, ar_hs, ar_ready, commit, wr_ok;
    logic [ADDR_WIDTH-1:0] aw_idx, ar_idx;

    assign aw_idx   = aw_addr_q >> LSB;
    assign ar_idx   = s_axil.ARADDR >> LSB;
    assign aw_hs    = s_axil.AWVALID && !aw_full_q;
    assign w_hs     = s_axil.WVALID && !w_full_q;
    assign ar_ready = !rvalid_q || s_axil.RREADY;
    assign ar_hs    = s_axil.ARVALID && ar_ready;
    assign commit   = aw_full_q && w_full_q && !bvalid_q;

    assign s_axil.AWREADY = !aw_full_q;
    assign s_axil.WREADY  = !w_full_q;
    assign s_axil.BVALID  = bvalid_q;
    assign s_axil.BRESP   = bresp_q;
    assign s_axil.ARREADY = ar_ready;
    assign s_axil.RVALID  = rvalid_q;
    assign s_axil.RDATA   = rdata_q;
    assign s_axil.RRESP   = rresp_q;
    assign reg_q          = regs_q;
    assign wr_pulse       = wr_pulse_q;

    // Fill the AW/W holding slots on their handshakes; a commit empties both.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axil.AWADDR;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axil.WDATA;
            w_strb_d = s_axil.WSTRB;
        end
    end

    // Decode the held address and apply byte-strobed updates on commit.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        wr_ok      = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx == ADDR_WIDTH'(i) && !RO_MASK[i]) begin
                wr_ok = 1'b1;
                if (commit) begin
                    wr_pulse_d[i] = 1'b1;
                    for (int k = 0; k < STRB_WIDTH; k++) begin
                        if (w_strb_q[k]) begin
                            regs_d[i*DATA_WIDTH + k*8 +: 8] = w_data_q[k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Write response: raised by a commit, held until BREADY.
    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil.BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Read data: registered from pre-commit register contents on AR handshake.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_idx == ADDR_WIDTH'(i)) begin
                    rresp_d = RESP_OKAY;
                    rdata_d = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH]
                                         : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end else if (s_axil.RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // Write-side state registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Read-side state registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end
endmodule

// File: tb/tb_axil_regbank.sv
// Self-checking bench for axil_regbank: directed vector table, hand-written
// corner sequences and a randomized phase against a register-array model.
module tb_axil_regbank;
    localparam int            DW = 32;
    localparam int            AW = 32;
    localparam int            NR = 4;
    localparam logic [NR-1:0] RO = 4'b1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axil_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
    logic [NR*DW-1:0] reg_q;
    logic [NR*DW-1:0] hw_in;
    logic [NR-1:0]    wr_pulse;

    axil_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
        .ACLK(clk), .ARESETn(rst_n), .s_axil(bus),
        .reg_q(reg_q), .hw_in(hw_in), .wr_pulse(wr_pulse)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] m_reg [NR];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          w_lead;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic bit writable(input logic [31:0] addr);
        int unsigned i = addr >> 2;
        return (i < NR) && !RO[i];
    endfunction

    function automatic logic [NR*DW-1:0] model_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_reg[i];
        return v;
    endfunction

    task automatic exp_rd(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        int unsigned i = addr >> 2;
        if (i >= NR) begin d = '0; r = 2'b10; end
        else if (RO[i]) begin d = hw_in[i*DW +: DW]; r = 2'b00; end
        else begin d = m_reg[i]; r = 2'b00; end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input bit collide, output logic [1:0] bresp);
        bit aw_done = 0, w_done = 0;
        int cyc = 0;
        int unsigned idx = addr >> 2;
        logic [31:0] old_rd;
        logic [1:0]  old_rr, eresp;
        logic [NR-1:0] epulse;
        logic [NR*DW-1:0] old_vec;
        eresp   = writable(addr) ? 2'b00 : 2'b10;
        epulse  = writable(addr) ? NR'(1 << idx) : '0;
        old_vec = model_vec();
        exp_rd(addr, old_rd, old_rr);
        while (!(aw_done && w_done) && cyc < 20) begin
            @(negedge clk);
            if (w_done && !aw_done) check("wready_low_while_held", bus.WREADY, 0);
            bus.WVALID  = !w_done;
            bus.WDATA   = data;
            bus.WSTRB   = strb;
            bus.AWVALID = !aw_done && (cyc >= w_lead);
            bus.AWADDR  = addr;
            #1;
            if (bus.WVALID && bus.WREADY) w_done = 1;
            if (bus.AWVALID && bus.AWREADY) aw_done = 1;
            cyc++;
        end
        if (!(aw_done && w_done)) timeout("write_accept");
        @(negedge clk);
        bus.AWVALID = 0;
        bus.WVALID  = 0;
        if (collide) begin bus.ARVALID = 1; bus.ARADDR = addr; end
        check("bvalid_n1", bus.BVALID, 0);
        check("wr_pulse_n1", wr_pulse, 0);
        check("reg_q_n1", reg_q, old_vec);
        if (writable(addr))
            for (int k = 0; k < 4; k++) if (strb[k]) m_reg[idx][k*8 +: 8] = data[k*8 +: 8];
        @(negedge clk);
        bus.ARVALID = 0;
        check("bvalid_n2", bus.BVALID, 1);
        check("bresp_n2", bus.BRESP, eresp);
        check("reg_q_n2", reg_q, model_vec());
        check("wr_pulse_n2", wr_pulse, epulse);
        bresp = bus.BRESP;
        if (collide) begin
            check("collide_rvalid", bus.RVALID, 1);
            check("collide_rdata_old", bus.RDATA, old_rd);
        end
        @(negedge clk);
        check("wr_pulse_n3", wr_pulse, 0);
        check("bvalid_n3", bus.BVALID, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        logic [31:0] ed;
        logic [1:0]  er;
        int t = 0;
        exp_rd(addr, ed, er);
        @(negedge clk);
        bus.ARVALID = 1;
        bus.ARADDR  = addr;
        #1;
        while (!bus.ARREADY && t < 20) begin @(negedge clk); #1; t++; end
        if (!bus.ARREADY) timeout("read_accept");
        @(negedge clk);
        bus.ARVALID = 0;
        check("rvalid", bus.RVALID, 1);
        check("rdata_model", bus.RDATA, ed);
        check("rresp_model", bus.RRESP, er);
        d = bus.RDATA;
        r = bus.RRESP;
    endtask

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd, e0, e1, e2;
        logic [1:0]  x0;

        tbl[0] = '{32'h08, 32'hA5A5A5A5, 4'hF, 0, 2'b00, 32'hA5A5A5A5, 2'b00};
        tbl[1] = '{32'h04, 32'h11223344, 4'hF, 0, 2'b00, 32'h11223344, 2'b00};
        tbl[2] = '{32'h04, 32'h0000BB00, 4'b0010, 3, 2'b00, 32'h1122BB44, 2'b00};
        tbl[3] = '{32'h40, 32'h12345678, 4'hF, 0, 2'b10, 32'h00000000, 2'b10};
        tbl[4] = '{32'h0C, 32'h12345678, 4'hF, 0, 2'b10, 32'hDEADBEEF, 2'b00};
        tbl[5] = '{32'h00, 32'hFFFFFFFF, 4'h0, 1, 2'b00, 32'h00000000, 2'b00};
        tbl[6] = '{32'h0B, 32'h0000005A, 4'h1, 0, 2'b00, 32'hA5A5A55A, 2'b00};

        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        hw_in = {32'hDEADBEEF, 32'h99999999, 32'h88888888, 32'h77777777};
        bus.AWVALID = 0; bus.AWADDR = '0; bus.WVALID = 0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.ARVALID = 0; bus.ARADDR = '0; bus.BREADY = 1; bus.RREADY = 1;
        rst_n = 1;
        #1 rst_n = 0;
        #1;
        check("rst_awready", bus.AWREADY, 1);
        check("rst_wready", bus.WREADY, 1);
        check("rst_arready", bus.ARREADY, 1);
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_reg_q", reg_q, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_rdata", bus.RDATA, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;

        for (int v = 0; v < 7; v++) begin
            do_write(tbl[v].addr, tbl[v].data, tbl[v].strb, tbl[v].w_lead, 0, br);
            check("tbl_bresp", br, tbl[v].exp_bresp);
            do_read(tbl[v].addr, rd, rr);
            check("tbl_rdata", rd, tbl[v].exp_rdata);
            check("tbl_rresp", rr, tbl[v].exp_rresp);
        end

        do_write(32'h08, 32'h0F0F0F0F, 4'hF, 0, 1, br);

        // B back-pressure with a second pair absorbed into the slots
        bus.BREADY = 0;
        @(negedge clk);
        bus.AWVALID = 1; bus.AWADDR = 32'h04; bus.WVALID = 1; bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF;
        @(negedge clk);
        bus.AWVALID = 0; bus.WVALID = 0;
        m_reg[1] = 32'hCAFEF00D;
        @(negedge clk);
        check("bp_bvalid_first", bus.BVALID, 1);
        check("bp_bresp_first", bus.BRESP, 2'b00);
        bus.AWVALID = 1; bus.AWADDR = 32'h0C; bus.WVALID = 1; bus.WDATA = 32'h00000001; bus.WSTRB = 4'hF;
        #1;
        check("bp_awready_free", bus.AWREADY, 1);
        check("bp_wready_free", bus.WREADY, 1);
        @(negedge clk);
        bus.AWVALID = 0; bus.WVALID = 0;
        check("bp_awready_full", bus.AWREADY, 0);
        check("bp_wready_full", bus.WREADY, 0);
        for (int c = 0; c < 4; c++) begin
            check("bp_bvalid_hold", bus.BVALID, 1);
            check("bp_bresp_hold", bus.BRESP, 2'b00);
            @(negedge clk);
        end
        bus.BREADY = 1;
        @(negedge clk);
        check("bp_bvalid_gap", bus.BVALID, 0);
        @(negedge clk);
        check("bp_bvalid_second", bus.BVALID, 1);
        check("bp_bresp_second", bus.BRESP, 2'b10);
        check("bp_reg_q", reg_q, model_vec());
        @(negedge clk);
        check("bp_bvalid_done", bus.BVALID, 0);

        // R back-pressure: beat held, ARREADY low, data stable
        bus.RREADY = 0;
        @(negedge clk);
        bus.ARVALID = 1; bus.ARADDR = 32'h0C;
        @(negedge clk);
        bus.ARADDR = 32'h04;
        #1;
        check("rbp_rvalid", bus.RVALID, 1);
        check("rbp_arready_low", bus.ARREADY, 0);
        check("rbp_rdata", bus.RDATA, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        check("rbp_rdata_stable", bus.RDATA, 32'hDEADBEEF);
        check("rbp_arready_still_low", bus.ARREADY, 0);
        bus.RREADY = 1;
        #1;
        check("rbp_arready_released", bus.ARREADY, 1);
        @(negedge clk);
        bus.ARVALID = 0;
        check("rbp_next_rvalid", bus.RVALID, 1);
        check("rbp_next_rdata", bus.RDATA, m_reg[1]);
        @(negedge clk);
        check("rbp_rvalid_done", bus.RVALID, 0);

        // Back-to-back reads, one beat per cycle
        exp_rd(32'h00, e0, x0);
        exp_rd(32'h04, e1, x0);
        exp_rd(32'h08, e2, x0);
        @(negedge clk);
        bus.ARVALID = 1; bus.ARADDR = 32'h00;
        @(negedge clk);
        bus.ARADDR = 32'h04;
        check("b2b_rvalid0", bus.RVALID, 1);
        check("b2b_rdata0", bus.RDATA, e0);
        @(negedge clk);
        bus.ARADDR = 32'h08;
        check("b2b_rvalid1", bus.RVALID, 1);
        check("b2b_rdata1", bus.RDATA, e1);
        @(negedge clk);
        bus.ARVALID = 0;
        check("b2b_rvalid2", bus.RVALID, 1);
        check("b2b_rdata2", bus.RDATA, e2);
        @(negedge clk);
        check("b2b_rvalid_end", bus.RVALID, 0);

        // Randomized writes and reads against the model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = 32'(($urandom_range(0, 6) << 2) | $urandom_range(0, 3));
            hw_in[3*DW +: DW] = $urandom;
            hw_in[0 +: DW]    = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                         writable(a) && ($urandom_range(0, 1) == 1), br);
            end else begin
                do_read(a, rd, rr);
            end
        end

        // Reset in the middle of a write and a read
        @(negedge clk);
        bus.AWVALID = 1; bus.AWADDR = 32'h00; bus.WVALID = 1; bus.WDATA = 32'h5555AAAA; bus.WSTRB = 4'hF;
        bus.ARVALID = 1; bus.ARADDR = 32'h04;
        @(negedge clk);
        bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
        check("pre_rst_rvalid", bus.RVALID, 1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_bvalid", bus.BVALID, 0);
        check("mid_rst_rvalid", bus.RVALID, 0);
        check("mid_rst_reg_q", reg_q, 0);
        check("mid_rst_awready", bus.AWREADY, 1);
        check("mid_rst_wready", bus.WREADY, 1);
        check("mid_rst_arready", bus.ARREADY, 1);
        check("mid_rst_rdata", bus.RDATA, 0);
        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("post_rst_bvalid", bus.BVALID, 0);
        check("post_rst_reg_q", reg_q, model_vec());
        check("post_rst_wr_pulse", wr_pulse, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axil_regbank.md
# axil_regbank

Parametrised AXI4-Lite slave register bank for the AXI-Lite subsystem. It replaces the fixed-width, fixed-behaviour slave with:
- a configurable register count;
- independent buffering of the AW and W channels;
- per-register read-only masking with hardware-sourced read values;
- SLVERR responses and single-cycle write pulses to the fabric.

It connects directly to the existing AXI-Lite master channel set.

## Interface
- DATA_WIDTH, 32, data bus width; 32 or 64 only.
- ADDR_WIDTH, 32, address bus width.
- NUM_REGS, 16, number of registers; 1 to 256.
- RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only.
- ACLK  in  1  clock, all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- AWADDR/AWVALID/AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel.
- WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1  read address channel.
- RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- reg_q  out  NUM_REGS*DATA_WIDTH  current contents of the writable registers; register i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- hw_in  in  NUM_REGS*DATA_WIDTH  read values for read-only registers; slices for writable registers are ignored.
- wr_pulse  out  NUM_REGS  one-cycle strobe for each successful write to register i.

## Operation
- Address decode:
  - LSB = log2(DATA_WIDTH/8); address bits below LSB are ignored.
  - Register index = addr >> LSB.
  - An index >= NUM_REGS is out of range.
- Write path:
  - The AW and W channels each have a one-entry holding slot (aw_full, w_full).
  - AWREADY = !aw_full; WREADY = !w_full. The two channels are accepted in any order or in the same cycle.
  - Commit happens on the edge where aw_full && w_full && !BVALID. On that edge both slots clear and BVALID sets.
  - Register byte k is updated only where WSTRB[k]=1.
  - BRESP=2'b00 (OKAY) for a writable register.
  - BRESP=2'b10 (SLVERR) for an out-of-range or RO register. In that case no register changes and no wr_pulse is generated.
  - A commit with WSTRB=0 is still OKAY and still pulses wr_pulse.
- Write response: BVALID and BRESP hold until the BREADY handshake. New AW/W beats may fill the emptied slots while B is pending; they commit after the B handshake.
- Read path:
  - ARREADY = !RVALID || RREADY, which gives one read per cycle under RREADY=1.
  - On the AR handshake, RDATA and RRESP are registered.
  - Writable register: RDATA = reg_q slice, RRESP=OKAY.
  - RO register: RDATA = hw_in slice sampled that cycle, RRESP=OKAY.
  - Out of range: RDATA=0, RRESP=SLVERR.
- Read/write collision: a read accepted in the same cycle as a commit to the same register returns the pre-write value.

## Timing
- Reset (ARESETn low, asynchronous):
  - all registers, reg_q, wr_pulse, RDATA cleared to 0;
  - BRESP and RRESP = 2'b00;
  - BVALID, RVALID, aw_full, w_full = 0.
  - AWREADY, WREADY and ARREADY read 1 during reset, as they are combinational from cleared state.
  - In-flight transactions are dropped with no response.
- Write latency: with the later of the AW/W handshakes in cycle n (and B free), commit occurs on the edge ending cycle n+1:
  - BVALID is high from cycle n+2;
  - reg_q shows the new value from cycle n+2;
  - wr_pulse[i] is high in cycle n+2 only.
- Write throughput: one write every 2 cycles with BREADY tied high.
- Read latency: AR handshake in cycle n gives RVALID in cycle n+1.
- Back-pressure:
  - RVALID stays high and RDATA stays stable until RREADY.
  - ARREADY is low while RVALID && !RREADY.
- Inputs are valid only when sampled on a handshake. VALID outputs never drop without a handshake except at reset.

## Test plan
- Reset with NUM_REGS=4: write 0xA5A5A5A5 to 0x08 with WSTRB=4'hF, AW and W in the same cycle -> BRESP=OKAY at cycle+2, reg_q[2]=0xA5A5A5A5, one wr_pulse[2] pulse; read 0x08 -> RDATA=0xA5A5A5A5.
- W presented 3 cycles before AW, WSTRB=4'b0010, WDATA=0x0000BB00 to register 1 holding 0x11223344 -> register 1 becomes 0x1122BB44; WREADY is low between the W handshake and the commit.
- Write and read at address 0x40 with NUM_REGS=4 -> BRESP=2'b10 and RRESP=2'b10 with RDATA=0; reg_q unchanged, no wr_pulse.
- RO_MASK=4'b1000, hw_in[3]=0xDEADBEEF: write 0x0C -> SLVERR with register unchanged; read 0x0C -> 0xDEADBEEF, OKAY.
- BREADY held low for 5 cycles after a write while a second AW/W pair arrives -> the second pair is absorbed into the slots; the second BVALID appears 2 cycles after the first B handshake, with correct ordering.
- Back-to-back reads of 0x00, 0x04, 0x08 with RREADY=1 -> one RVALID beat per cycle in order; then assert ARESETn low mid-transaction -> all VALIDs drop immediately and reg_q returns to 0.
